// File: rtl/channel_frontend_pkg.sv
// Shared definitions for the channel A/B frontend: FSM state encoding, tag
// bit positions and parity/sizing helpers.
package channel_frontend_pkg;

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_ARMING   = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_DRAINING = 2'd3
  } state_e;

  localparam int NUM_IN_TAGS  = 6;
  localparam int NUM_OUT_TAGS = 7;

  // Bit positions of the inbound tags inside the packed inbound tag vector
  localparam int TAG_SERVICE     = 0;
  localparam int TAG_STATUS      = 1;
  localparam int TAG_ADDRESS     = 2;
  localparam int TAG_OPERATIONAL = 3;
  localparam int TAG_SELECT      = 4;
  localparam int TAG_REQUEST     = 5;

  // Parity bit that makes data plus parity contain an odd number of ones.
  // Narrower buses are zero-extended, which leaves the XOR unchanged.
  function automatic logic odd_parity_bit(input logic [63:0] data);
    return ~(^data);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int counter_width(input int a, input int b, input int c);
    int m;
    m = max3(a, b, c);
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/channel_frontend_tag_filter.sv
// One-bit synchronizer followed by an optional consecutive-cycle glitch filter.
// FILTER_CYCLES=0 turns the filter into a plain wire after the synchronizer.
module channel_frontend_tag_filter #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   FILTER_CYCLES = 2,
  parameter logic RESET_VAL     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_r;

  // Synchronizer shift chain, loaded with the inactive level on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
    end
  end

  if (FILTER_CYCLES == 0) begin : g_nofilt
    assign q = sync_r[SYNC_STAGES-1];
  end else begin : g_filt
    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

    logic [CW-1:0] cnt_r;
    logic          filt_r;
    logic          synced_s;

    assign synced_s = sync_r[SYNC_STAGES-1];

    // Count consecutive disagreeing cycles; any agreement restarts the count
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        filt_r <= RESET_VAL;
        cnt_r  <= CW'(0);
      end else if (synced_s != filt_r) begin
        if (cnt_r >= LAST) begin
          filt_r <= synced_s;
          cnt_r  <= CW'(0);
        end else begin
          cnt_r  <= cnt_r + CW'(1);
        end
      end else begin
        cnt_r <= CW'(0);
      end
    end

    assign q = filt_r;
  end

endmodule

// File: rtl/channel_frontend.sv
// Channel B (internal, active-high) to channel A (external pads) frontend with
// inbound sync/filtering, odd bus parity and an arm/drain driver-enable sequencer.
module channel_frontend
  import channel_frontend_pkg::*;
#(
  parameter int BUS_WIDTH     = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 2,
  parameter int ARM_CYCLES    = 4,
  parameter int DRAIN_CYCLES  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [BUS_WIDTH-1:0] b_bus_out,
  input  logic                 b_operational_out,
  input  logic                 b_hold_out,
  input  logic                 b_select_out,
  input  logic                 b_address_out,
  input  logic                 b_command_out,
  input  logic                 b_service_out,
  input  logic                 b_suppress_out,
  output logic [BUS_WIDTH-1:0] b_bus_in,
  output logic                 b_request_in,
  output logic                 b_select_in,
  output logic                 b_operational_in,
  output logic                 b_address_in,
  output logic                 b_status_in,
  output logic                 b_service_in,
  output logic                 b_parity_error,
  output logic                 b_ready,
  input  logic [BUS_WIDTH-1:0] a_bus_in_n,
  input  logic                 a_bus_in_p_n,
  input  logic                 a_request_in_n,
  input  logic                 a_select_in_n,
  input  logic                 a_operational_in_n,
  input  logic                 a_address_in_n,
  input  logic                 a_status_in_n,
  input  logic                 a_service_in_n,
  output logic [BUS_WIDTH-1:0] a_bus_out,
  output logic                 a_bus_out_p,
  output logic                 a_operational_out,
  output logic                 a_hold_out,
  output logic                 a_select_out,
  output logic                 a_address_out,
  output logic                 a_command_out,
  output logic                 a_service_out,
  output logic                 a_suppress_out,
  output logic                 driver_enable
);

  localparam int CNT_W = counter_width(ARM_CYCLES, DRAIN_CYCLES, FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ARM_LAST   = CNT_W'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  logic [NUM_IN_TAGS-1:0]  tag_n_s;
  logic [NUM_IN_TAGS-1:0]  tag_raw_s;
  logic [NUM_IN_TAGS-1:0]  tag_s;
  logic [BUS_WIDTH-1:0]    bus_raw_s;
  logic [BUS_WIDTH-1:0]    bus_s;
  logic                    par_raw_s;
  logic                    par_s;
  logic                    prev_status_r;
  logic                    prev_service_r;
  logic                    rise_s;
  logic                    parity_bad_s;

  state_e                  state_r;
  state_e                  next_state_s;
  logic [CNT_W-1:0]        cnt_r;

  logic                    active_s;
  logic                    drv_en_s;
  logic [NUM_OUT_TAGS-1:0] b_out_tags_s;
  logic [NUM_OUT_TAGS-1:0] a_tags_s;
  logic [BUS_WIDTH-1:0]    a_bus_s;
  logic                    a_par_s;
  logic [BUS_WIDTH-1:0]    b_bus_s;
  logic [NUM_IN_TAGS-1:0]  b_tags_s;
  logic                    perr_s;

  assign tag_n_s[TAG_REQUEST]     = a_request_in_n;
  assign tag_n_s[TAG_SELECT]      = a_select_in_n;
  assign tag_n_s[TAG_OPERATIONAL] = a_operational_in_n;
  assign tag_n_s[TAG_ADDRESS]     = a_address_in_n;
  assign tag_n_s[TAG_STATUS]      = a_status_in_n;
  assign tag_n_s[TAG_SERVICE]     = a_service_in_n;

  for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_bus
    channel_frontend_tag_filter #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(0),
      .RESET_VAL    (1'b1)
    ) u_bus_sync (
      .clk  (clk),
      .reset(reset),
      .din  (a_bus_in_n[i]),
      .q    (bus_raw_s[i])
    );
  end

  channel_frontend_tag_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(0),
    .RESET_VAL    (1'b1)
  ) u_par_sync (
    .clk  (clk),
    .reset(reset),
    .din  (a_bus_in_p_n),
    .q    (par_raw_s)
  );

  for (genvar t = 0; t < NUM_IN_TAGS; t++) begin : g_tag
    channel_frontend_tag_filter #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RESET_VAL    (1'b1)
    ) u_tag_filter (
      .clk  (clk),
      .reset(reset),
      .din  (tag_n_s[t]),
      .q    (tag_raw_s[t])
    );
  end

  assign bus_s = ~bus_raw_s;
  assign par_s = ~par_raw_s;
  assign tag_s = ~tag_raw_s;

  // Previous filtered status/service, for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_status_r  <= 1'b0;
      prev_service_r <= 1'b0;
    end else begin
      prev_status_r  <= tag_s[TAG_STATUS];
      prev_service_r <= tag_s[TAG_SERVICE];
    end
  end

  // Simultaneous status and service rises merge into one check
  assign rise_s       = (tag_s[TAG_STATUS] & ~prev_status_r) |
                        (tag_s[TAG_SERVICE] & ~prev_service_r);
  assign parity_bad_s = (par_s != odd_parity_bit(64'(bus_s)));

  // Sequencer state and dwell counter; counter restarts on every state change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_OFF;
      cnt_r   <= CNT_W'(0);
    end else begin
      state_r <= next_state_s;
      if (next_state_s != state_r) begin
        cnt_r <= CNT_W'(0);
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Next-state logic; draining always runs to completion before OFF
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_OFF: begin
        if (enable) next_state_s = ST_ARMING;
        else        next_state_s = ST_OFF;
      end
      ST_ARMING: begin
        if (!enable)                next_state_s = ST_OFF;
        else if (cnt_r == ARM_LAST) next_state_s = ST_ACTIVE;
        else                        next_state_s = ST_ARMING;
      end
      ST_ACTIVE: begin
        if (!enable) next_state_s = ST_DRAINING;
        else         next_state_s = ST_ACTIVE;
      end
      ST_DRAINING: begin
        if (cnt_r == DRAIN_LAST) next_state_s = ST_OFF;
        else                     next_state_s = ST_DRAINING;
      end
      default: next_state_s = ST_OFF;
    endcase
  end

  // Output decode from the upcoming state so registered outputs track the state register
  always_comb begin
    active_s     = (next_state_s == ST_ACTIVE);
    drv_en_s     = (next_state_s != ST_OFF);
    b_out_tags_s = {b_operational_out, b_hold_out, b_select_out, b_address_out,
                    b_command_out, b_service_out, b_suppress_out};
    if (active_s) begin
      a_bus_s  = b_bus_out;
      a_par_s  = odd_parity_bit(64'(b_bus_out));
      a_tags_s = b_out_tags_s;
      b_bus_s  = bus_s;
      b_tags_s = tag_s;
      perr_s   = rise_s & parity_bad_s;
    end else begin
      a_bus_s  = {BUS_WIDTH{1'b0}};
      a_par_s  = 1'b0;
      a_tags_s = {NUM_OUT_TAGS{1'b0}};
      b_bus_s  = {BUS_WIDTH{1'b0}};
      b_tags_s = {NUM_IN_TAGS{1'b0}};
      b_tags_s[TAG_SELECT] = b_select_out;
      perr_s   = 1'b0;
    end
  end

  // Output registers, cleared asynchronously so reset releases the pads at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      driver_enable    <= 1'b0;
      b_ready          <= 1'b0;
      a_bus_out        <= {BUS_WIDTH{1'b0}};
      a_bus_out_p      <= 1'b0;
      {a_operational_out, a_hold_out, a_select_out, a_address_out,
       a_command_out, a_service_out, a_suppress_out} <= {NUM_OUT_TAGS{1'b0}};
      b_bus_in         <= {BUS_WIDTH{1'b0}};
      b_request_in     <= 1'b0;
      b_select_in      <= 1'b0;
      b_operational_in <= 1'b0;
      b_address_in     <= 1'b0;
      b_status_in      <= 1'b0;
      b_service_in     <= 1'b0;
      b_parity_error   <= 1'b0;
    end else begin
      driver_enable    <= drv_en_s;
      b_ready          <= active_s;
      a_bus_out        <= a_bus_s;
      a_bus_out_p      <= a_par_s;
      {a_operational_out, a_hold_out, a_select_out, a_address_out,
       a_command_out, a_service_out, a_suppress_out} <= a_tags_s;
      b_bus_in         <= b_bus_s;
      b_request_in     <= b_tags_s[TAG_REQUEST];
      b_select_in      <= b_tags_s[TAG_SELECT];
      b_operational_in <= b_tags_s[TAG_OPERATIONAL];
      b_address_in     <= b_tags_s[TAG_ADDRESS];
      b_status_in      <= b_tags_s[TAG_STATUS];
      b_service_in     <= b_tags_s[TAG_SERVICE];
      b_parity_error   <= perr_s;
    end
  end

endmodule

// File: tb/tb_channel_frontend.sv
// Self-checking bench for channel_frontend: directed sequencing/filter/parity/
// loopback/reset steps plus randomized traffic against a history-based model.
module tb_channel_frontend;

  localparam int SYNC  = 2;
  localparam int FILT  = 2;
  localparam int ARM   = 4;
  localparam int DRAIN = 4;
  localparam int MAXE  = 8192;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] b_bus_out = 8'h00;
  logic [6:0] b_otags = 7'h00;     // {op,hold,sel,addr,cmd,serv,supp}
  logic [7:0] a_bus_in_n = 8'hFF;
  logic       a_bus_in_p_n = 1'b1;
  logic [5:0] a_tags_n = 6'h3F;    // {req,sel,op,addr,status,service}

  logic [7:0] b_bus_in, a_bus_out;
  logic b_request_in, b_select_in, b_operational_in, b_address_in, b_status_in, b_service_in;
  logic b_parity_error, b_ready, a_bus_out_p, driver_enable;
  logic a_operational_out, a_hold_out, a_select_out, a_address_out;
  logic a_command_out, a_service_out, a_suppress_out;
  logic [5:0] b_itags;
  logic [6:0] a_otags;

  assign b_itags = {b_request_in, b_select_in, b_operational_in, b_address_in, b_status_in, b_service_in};
  assign a_otags = {a_operational_out, a_hold_out, a_select_out, a_address_out,
                    a_command_out, a_service_out, a_suppress_out};

  channel_frontend dut (
    .clk(clk), .reset(reset), .enable(enable),
    .b_bus_out(b_bus_out),
    .b_operational_out(b_otags[6]), .b_hold_out(b_otags[5]), .b_select_out(b_otags[4]),
    .b_address_out(b_otags[3]), .b_command_out(b_otags[2]), .b_service_out(b_otags[1]),
    .b_suppress_out(b_otags[0]),
    .b_bus_in(b_bus_in),
    .b_request_in(b_request_in), .b_select_in(b_select_in), .b_operational_in(b_operational_in),
    .b_address_in(b_address_in), .b_status_in(b_status_in), .b_service_in(b_service_in),
    .b_parity_error(b_parity_error), .b_ready(b_ready),
    .a_bus_in_n(a_bus_in_n), .a_bus_in_p_n(a_bus_in_p_n),
    .a_request_in_n(a_tags_n[5]), .a_select_in_n(a_tags_n[4]), .a_operational_in_n(a_tags_n[3]),
    .a_address_in_n(a_tags_n[2]), .a_status_in_n(a_tags_n[1]), .a_service_in_n(a_tags_n[0]),
    .a_bus_out(a_bus_out), .a_bus_out_p(a_bus_out_p),
    .a_operational_out(a_operational_out), .a_hold_out(a_hold_out), .a_select_out(a_select_out),
    .a_address_out(a_address_out), .a_command_out(a_command_out), .a_service_out(a_service_out),
    .a_suppress_out(a_suppress_out),
    .driver_enable(driver_enable)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: raw input history per edge, filtered (raw-polarity) tags, phase + dwell
  int         e;
  logic [7:0] h_bus [0:MAXE-1];
  logic       h_par [0:MAXE-1];
  logic [5:0] h_tag [0:MAXE-1];
  logic [5:0] f, fprev;
  int         phase;   // 0 off, 1 arming, 2 active, 3 draining
  int         n;
  logic [7:0] exp_abus, exp_bbus;
  logic [6:0] exp_atags;
  logic [5:0] exp_btags;
  logic       exp_ap, exp_drv, exp_ready, exp_perr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gb(input int i);
    return (i < 1) ? 8'hFF : h_bus[i];
  endfunction
  function automatic logic gp(input int i);
    return (i < 1) ? 1'b1 : h_par[i];
  endfunction
  function automatic logic [5:0] gt(input int i);
    return (i < 1) ? 6'h3F : h_tag[i];
  endfunction

  task automatic model_reset();
    e = 0; f = 6'h3F; fprev = 6'h3F; phase = 0; n = 0;
  endtask

  task automatic model_edge();
    logic       act, rise, flip;
    logic [7:0] bus_sync;
    logic       par_sync;
    logic [5:0] w;
    e++;
    if (e >= MAXE) begin
      $display("FAIL model_overflow: observed %0d expected below %0d", e, MAXE);
      $fatal(1);
    end
    h_bus[e] = a_bus_in_n; h_par[e] = a_bus_in_p_n; h_tag[e] = a_tags_n;
    case (phase)
      0: if (enable) begin phase = 1; n = 1; end
      1: if (!enable) phase = 0;
         else if (n == ARM) phase = 2;
         else n++;
      2: if (!enable) begin phase = 3; n = 1; end
      3: if (n == DRAIN) phase = 0;
         else n++;
      default: phase = 0;
    endcase
    act       = (phase == 2);
    exp_drv   = (phase != 0);
    exp_ready = act;
    exp_abus  = act ? b_bus_out : 8'h00;
    exp_ap    = act ? (($countones(b_bus_out) % 2) == 0) : 1'b0;
    exp_atags = act ? b_otags : 7'h00;
    bus_sync  = ~gb(e - SYNC);
    par_sync  = ~gp(e - SYNC);
    exp_bbus  = act ? bus_sync : 8'h00;
    exp_btags = act ? ~f : {1'b0, b_otags[4], 4'b0000};
    rise      = (~f[1] & fprev[1]) | (~f[0] & fprev[0]);
    exp_perr  = act && rise && ((($countones(bus_sync) + int'(par_sync)) % 2) == 0);
    fprev = f;
    for (int t = 0; t < 6; t++) begin
      flip = 1'b1;
      for (int j = 0; j < FILT; j++) begin
        w = gt(e - SYNC - j);
        if (w[t] == f[t]) flip = 1'b0;
      end
      if (flip) f[t] = ~f[t];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    chk("driver_enable", driver_enable, exp_drv);
    chk("b_ready", b_ready, exp_ready);
    chk("a_bus_out", a_bus_out, exp_abus);
    chk("a_bus_out_p", a_bus_out_p, exp_ap);
    chk("a_tags", a_otags, exp_atags);
    chk("b_bus_in", b_bus_in, exp_bbus);
    chk("b_tags", b_itags, exp_btags);
    chk("b_parity_error", b_parity_error, exp_perr);
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_drv"}, driver_enable, 1'b0);
    chk({tag, "_ready"}, b_ready, 1'b0);
    chk({tag, "_a_bus"}, a_bus_out, 8'h00);
    chk({tag, "_a_p"}, a_bus_out_p, 1'b0);
    chk({tag, "_a_tags"}, a_otags, 7'h00);
    chk({tag, "_b_bus"}, b_bus_in, 8'h00);
    chk({tag, "_b_tags"}, b_itags, 6'h00);
    chk({tag, "_perr"}, b_parity_error, 1'b0);
  endtask

  int pulses;

  initial begin
    // Reset state
    #1;
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();

    // Abort during arming cycle 2
    enable = 1'b1;
    steps(2);
    enable = 1'b0;
    step();
    chk("abort_drv", driver_enable, 1'b0);
    chk("abort_ready", b_ready, 1'b0);
    steps(2);

    // Arm / active / drain sequencing
    b_bus_out = 8'h5A; b_otags = 7'h7F;
    enable = 1'b1;
    step();
    chk("arm_drv", driver_enable, 1'b1);
    chk("arm_a_bus", a_bus_out, 8'h00);
    steps(3);
    chk("arm_end_ready", b_ready, 1'b0);
    step();
    chk("active_ready", b_ready, 1'b1);
    chk("active_a_bus", a_bus_out, 8'h5A);
    enable = 1'b0;
    step();
    chk("drain_a_bus", a_bus_out, 8'h00);
    chk("drain_drv", driver_enable, 1'b1);
    steps(3);
    chk("drain_end_drv", driver_enable, 1'b1);
    step();
    chk("off_drv", driver_enable, 1'b0);

    // Randomized traffic with occasional enable toggles
    enable = 1'b1;
    for (int c = 0; c < 400; c++) begin
      b_bus_out    = 8'($urandom);
      b_otags      = 7'($urandom);
      a_bus_in_n   = 8'($urandom);
      a_bus_in_p_n = 1'($urandom);
      for (int t = 0; t < 6; t++)
        if ($urandom_range(0, 4) == 0) a_tags_n[t] = ~a_tags_n[t];
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      step();
    end

    // Settle into ACTIVE with quiet inbound tags
    enable = 1'b0; a_tags_n = 6'h3F;
    steps(10);
    enable = 1'b1;
    steps(6);
    chk("settle_ready", b_ready, 1'b1);

    // Glitch filter: one-cycle low pulse is ignored
    a_tags_n[1] = 1'b0;
    step();
    a_tags_n[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("glitch_status", b_status_in, 1'b0);
    end
    // Three-cycle low: rises on edge 5
    a_tags_n[1] = 1'b0;
    steps(3);
    a_tags_n[1] = 1'b1;
    step();
    chk("filt_edge4", b_status_in, 1'b0);
    step();
    chk("filt_edge5", b_status_in, 1'b1);
    steps(6);

    // Parity: good parity on service rise -> no pulse
    a_bus_in_n = ~8'h01; a_bus_in_p_n = 1'b1;
    steps(4);
    pulses = 0;
    a_tags_n[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (b_parity_error) pulses++;
    end
    chk("parity_good_pulses", pulses, 0);
    // Bad parity on service rise -> single pulse
    a_tags_n[0] = 1'b1;
    steps(6);
    a_bus_in_p_n = 1'b0;
    steps(4);
    pulses = 0;
    a_tags_n[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (b_parity_error) pulses++;
    end
    chk("parity_bad_pulses", pulses, 1);

    // Outbound parity
    b_bus_out = 8'h03;
    step();
    chk("out_par_03", a_bus_out_p, 1'b1);
    chk("out_bus_03", a_bus_out, 8'h03);

    // Select loopback while not active
    enable = 1'b0; b_otags = 7'h00;
    steps(6);
    b_otags[4] = 1'b1;
    step();
    chk("loop_sel", b_select_in, 1'b1);
    chk("loop_others", {b_request_in, b_operational_in, b_address_in, b_status_in, b_service_in}, 5'h00);

    // Asynchronous reset mid-ACTIVE with outputs driven
    enable = 1'b1;
    steps(6);
    b_bus_out = 8'hA5; b_otags = 7'h20;
    step();
    chk("pre_rst_a_bus", a_bus_out, 8'hA5);
    chk("pre_rst_hold", a_hold_out, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    step();
    chk("post_rst_drv", driver_enable, 1'b1);
    chk("post_rst_ready", b_ready, 1'b0);
    steps(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
